// File: rtl/life_pkg.sv
// ---------------------------------------------------------------------------
// life_pkg
// Shared types and helpers for the Game-of-Life generation sequencer:
//   - state_e       : sequencer FSM states (READ uses a separate k counter)
//   - colour constants for live / dead cells
//   - nb_offset()   : neighbour offset table, k = 0..8 in row-major (dy,dx)
//   - next_cell()   : B3/S23 rule
// ---------------------------------------------------------------------------
package life_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_EVAL,
        ST_PLOT,
        ST_FLIP
    } state_e;

    localparam logic [2:0] COLOUR_ALIVE_DEF = 3'b111;
    localparam logic [2:0] COLOUR_DEAD_DEF  = 3'b000;

    // Index of the last neighbour read and of the cell itself.
    localparam logic [3:0] K_LAST = 4'd8;
    localparam logic [3:0] K_SELF = 4'd4;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } nb_offset_t;

    // Row-major walk from (-1,-1) to (+1,+1); k=4 is the centre cell.
    function automatic nb_offset_t nb_offset(input logic [3:0] k);
        nb_offset_t off;
        case (k)
            4'd0:    off = '{dx: -2'sd1, dy: -2'sd1};
            4'd1:    off = '{dx:  2'sd0, dy: -2'sd1};
            4'd2:    off = '{dx:  2'sd1, dy: -2'sd1};
            4'd3:    off = '{dx: -2'sd1, dy:  2'sd0};
            4'd5:    off = '{dx:  2'sd1, dy:  2'sd0};
            4'd6:    off = '{dx: -2'sd1, dy:  2'sd1};
            4'd7:    off = '{dx:  2'sd0, dy:  2'sd1};
            4'd8:    off = '{dx:  2'sd1, dy:  2'sd1};
            default: off = '{dx:  2'sd0, dy:  2'sd0};
        endcase
        return off;
    endfunction

    // Birth on exactly 3 neighbours, survival on 2 or 3.
    function automatic logic next_cell(input logic self_alive, input logic [3:0] n);
        return (n == 4'd3) || (self_alive && (n == 4'd2));
    endfunction

endpackage

// File: rtl/life_neighbour_addr.sv
// ---------------------------------------------------------------------------
// life_neighbour_addr
// Combinational neighbour address generator.
//   x, y     : current cell coordinate
//   k        : neighbour index 0..8 (row-major, 4 = the cell itself)
//   nb_x/nb_y: coordinate to read
//   nb_valid : 0 when the neighbour lies off-grid and must count as dead
// Build option LIFE_WRAP_EN: when defined the grid is toroidal (edges wrap,
// nb_valid always 1); otherwise off-grid reads are clamped and masked.
// ---------------------------------------------------------------------------
module life_neighbour_addr
    import life_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 12,
    parameter int X_BITS = 4,
    parameter int Y_BITS = 4
) (
    input  logic [X_BITS-1:0] x,
    input  logic [Y_BITS-1:0] y,
    input  logic [3:0]        k,
    output logic [X_BITS-1:0] nb_x,
    output logic [Y_BITS-1:0] nb_y,
    output logic              nb_valid
);

    localparam logic [X_BITS-1:0] X_MAX = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(GRID_H - 1);
    localparam logic signed [X_BITS+1:0] X_LIM = (X_BITS+2)'(GRID_W);
    localparam logic signed [Y_BITS+1:0] Y_LIM = (Y_BITS+2)'(GRID_H);

    nb_offset_t               off;
    logic signed [X_BITS+1:0] sx;
    logic signed [Y_BITS+1:0] sy;
    logic                     x_lo, x_hi, y_lo, y_hi;

    always_comb begin
        off = nb_offset(k);
        // Two guard bits let the sum go to -1 or GRID_W without aliasing.
        sx = $signed({2'b00, x}) + $signed({{X_BITS{off.dx[1]}}, off.dx});
        sy = $signed({2'b00, y}) + $signed({{Y_BITS{off.dy[1]}}, off.dy});
        x_lo = sx[X_BITS+1];
        y_lo = sy[Y_BITS+1];
        x_hi = (sx >= X_LIM);
        y_hi = (sy >= Y_LIM);
`ifdef LIFE_WRAP_EN
        nb_valid = 1'b1;
        nb_x = x_lo ? X_MAX : (x_hi ? '0 : sx[X_BITS-1:0]);
        nb_y = y_lo ? Y_MAX : (y_hi ? '0 : sy[Y_BITS-1:0]);
`else
        nb_valid = !(x_lo || x_hi || y_lo || y_hi);
        nb_x = x_lo ? '0 : (x_hi ? X_MAX : sx[X_BITS-1:0]);
        nb_y = y_lo ? '0 : (y_hi ? Y_MAX : sy[Y_BITS-1:0]);
`endif
    end

endmodule

// File: rtl/life_gen_sequencer.sv
// ---------------------------------------------------------------------------
// life_gen_sequencer
// Runs one Game-of-Life generation over a GRID_W x GRID_H double-banked
// cell RAM: per cell, 9 reads from the current bank, one write of the B3/S23
// result to the other bank, one plot request; banks flip at generation end.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   go / step / stop  : run-latch set, single-generation pulse, halt request
//   rd_addr, rd_data  : cell RAM read {bank,y,x}; data one cycle later
//   wr_en/addr/data   : cell RAM write {~bank,y,x}
//   plot_*            : valid/ready plot request with cell x/y and colour
//   busy, done        : generation in progress, end-of-generation pulse
//   bank, gen_count   : displayed bank, completed generation count
// Build option LIFE_WRAP_EN: toroidal grid (see life_neighbour_addr).
// ---------------------------------------------------------------------------
module life_gen_sequencer
    import life_pkg::*;
#(
    parameter int         GRID_W       = 16,
    parameter int         GRID_H       = 12,
    parameter int         X_BITS       = 4,
    parameter int         Y_BITS       = 4,
    parameter logic [2:0] COLOUR_ALIVE = COLOUR_ALIVE_DEF,
    parameter logic [2:0] COLOUR_DEAD  = COLOUR_DEAD_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     go,
    input  logic                     step,
    input  logic                     stop,
    output logic [Y_BITS+X_BITS:0]   rd_addr,
    input  logic                     rd_data,
    output logic                     wr_en,
    output logic [Y_BITS+X_BITS:0]   wr_addr,
    output logic                     wr_data,
    output logic                     plot_valid,
    input  logic                     plot_ready,
    output logic [X_BITS-1:0]        plot_x,
    output logic [Y_BITS-1:0]        plot_y,
    output logic [2:0]               plot_colour,
    output logic                     busy,
    output logic                     done,
    output logic                     bank,
    output logic [15:0]              gen_count
);

    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(GRID_H - 1);

    state_e              state_q, state_d;
    logic [3:0]          k_q, k_d;
    logic [X_BITS-1:0]   x_q, x_d;
    logic [Y_BITS-1:0]   y_q, y_d;
    logic                bank_q, bank_d;
    logic                run_q, run_d;
    logic [15:0]         gen_q, gen_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                self_q, self_d;
    logic                mask_q, mask_d;    // validity of the read now in flight
    logic                alive_q, alive_d;  // value written, reused for plot colour

    logic [X_BITS-1:0]   nb_x;
    logic [Y_BITS-1:0]   nb_y;
    logic                nb_valid;
    logic [3:0]          n_total;

    life_neighbour_addr #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
    ) u_nb (
        .x        (x_q),
        .y        (y_q),
        .k        (k_q),
        .nb_x     (nb_x),
        .nb_y     (nb_y),
        .nb_valid (nb_valid)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        x_d         = x_q;
        y_d         = y_q;
        bank_d      = bank_q;
        gen_d       = gen_q;
        cnt_d       = cnt_q;
        self_d      = self_q;
        mask_d      = mask_q;
        alive_d     = alive_q;
        rd_addr     = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = 1'b0;
        plot_valid  = 1'b0;
        plot_x      = '0;
        plot_y      = '0;
        plot_colour = '0;
        done        = 1'b0;

        // stop wins over go; go alone only ever sets the latch.
        run_d   = stop ? 1'b0 : (go ? 1'b1 : run_q);
        // Data returning now belongs to the read issued last cycle.
        n_total = cnt_q + {3'b000, rd_data & mask_q};

        case (state_q)
            ST_IDLE: begin
                if (!stop && (step || run_q)) begin
                    state_d = ST_READ;
                    k_d     = '0;
                end
            end
            ST_READ: begin
                rd_addr = {bank_q, nb_y, nb_x};
                mask_d  = nb_valid;
                if (k_q == 4'd0) begin
                    cnt_d  = '0;
                    self_d = 1'b0;
                end else if (k_q == K_SELF + 4'd1) begin
                    self_d = rd_data;
                end else begin
                    cnt_d = n_total;
                end
                if (k_q == K_LAST) state_d = ST_EVAL;
                else               k_d     = k_q + 4'd1;
            end
            ST_EVAL: begin
                alive_d = next_cell(self_q, n_total);
                wr_en   = 1'b1;
                wr_addr = {~bank_q, y_q, x_q};
                wr_data = alive_d;
                state_d = ST_PLOT;
            end
            ST_PLOT: begin
                plot_valid  = 1'b1;
                plot_x      = x_q;
                plot_y      = y_q;
                plot_colour = alive_q ? COLOUR_ALIVE : COLOUR_DEAD;
                if (plot_ready) begin
                    k_d     = '0;
                    state_d = ST_READ;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d     = '0;
                            state_d = ST_FLIP;
                        end else begin
                            y_d = y_q + Y_BITS'(1);
                        end
                    end else begin
                        x_d = x_q + X_BITS'(1);
                    end
                end
            end
            ST_FLIP: begin
                bank_d = ~bank_q;
                gen_d  = gen_q + 16'd1;
                done   = 1'b1;
                k_d    = '0;
                state_d = (stop || !run_q) ? ST_IDLE : ST_READ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            bank_q  <= 1'b0;
            run_q   <= 1'b0;
            gen_q   <= '0;
            cnt_q   <= '0;
            self_q  <= 1'b0;
            mask_q  <= 1'b0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            bank_q  <= bank_d;
            run_q   <= run_d;
            gen_q   <= gen_d;
            cnt_q   <= cnt_d;
            self_q  <= self_d;
            mask_q  <= mask_d;
            alive_q <= alive_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign bank      = bank_q;
    assign gen_count = gen_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// ---------------------------------------------------------------------------
// tb_life_gen_sequencer
// Self-checking bench for life_gen_sequencer on a 5x5 grid with a
// double-banked cell RAM model and a whole-grid Game-of-Life reference.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_life_gen_sequencer;

    localparam int GW    = 5;
    localparam int GH    = 5;
    localparam int XB    = 4;
    localparam int YB    = 4;
    localparam int AW    = 1 + YB + XB;
    localparam int NCELL = GW * GH;
    localparam int GEN_CYC = 11 * NCELL + 1;

    logic           clock = 1'b0;
    logic           reset, go, step, stop, rd_data, plot_ready;
    logic           wr_en, wr_data, plot_valid, busy, done, bank;
    logic [AW-1:0]  rd_addr, wr_addr;
    logic [XB-1:0]  plot_x;
    logic [YB-1:0]  plot_y;
    logic [2:0]     plot_colour;
    logic [15:0]    gen_count;

    always #5 clock = ~clock;

    life_gen_sequencer #(
        .GRID_W (GW), .GRID_H (GH), .X_BITS (XB), .Y_BITS (YB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .go          (go),
        .step        (step),
        .stop        (stop),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .plot_valid  (plot_valid),
        .plot_ready  (plot_ready),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour),
        .busy        (busy),
        .done        (done),
        .bank        (bank),
        .gen_count   (gen_count)
    );

    // Cell RAM: synchronous read, data valid the cycle after the address.
    logic mem [2**AW];
    always @(posedge clock) begin
        rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Random plotter backpressure, enabled only for the random phase.
    bit rand_ready_en = 1'b0;
    always @(negedge clock) if (rand_ready_en) plot_ready = ($urandom_range(0, 3) != 0);

    // Activity monitor, sampled after inputs have settled for the cycle.
    int busy_cyc, wr_cnt, plot_cnt, done_cnt;
    bit plot_img [NCELL];
    always @(negedge clock) begin
        #1;
        if (busy) busy_cyc++;
        if (wr_en) wr_cnt++;
        if (done) done_cnt++;
        if (plot_valid && plot_ready && int'(plot_x) < GW && int'(plot_y) < GH) begin
            plot_cnt++;
            plot_img[int'(plot_y) * GW + int'(plot_x)] = (plot_colour == 3'b111);
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit model [NCELL];
    int exp_gen;
    bit exp_bank;

    function automatic int live_neighbours(input int x, input int y);
        int n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                int xx, yy;
                if (dx == 0 && dy == 0) continue;
                xx = x + dx;
                yy = y + dy;
`ifdef LIFE_WRAP_EN
                xx = (xx + GW) % GW;
                yy = (yy + GH) % GH;
`else
                if (xx < 0 || xx >= GW || yy < 0 || yy >= GH) continue;
`endif
                n += int'(model[yy * GW + xx]);
            end
        end
        return n;
    endfunction

    task automatic model_step();
        bit nxt [NCELL];
        for (int y = 0; y < GH; y++) begin
            for (int x = 0; x < GW; x++) begin
                int n = live_neighbours(x, y);
                nxt[y * GW + x] = (n == 3) || (model[y * GW + x] && n == 2);
            end
        end
        model    = nxt;
        exp_bank = ~exp_bank;
        exp_gen  = (exp_gen + 1) % 65536;
    endtask

    function automatic int addr_of(input bit b, input int x, input int y);
        return int'(b) * (2 ** (XB + YB)) + y * (2 ** XB) + x;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NCELL; i++) model[i] = 1'b0;
    endtask

    task automatic random_model();
        for (int i = 0; i < NCELL; i++) model[i] = ($urandom_range(0, 2) == 0);
    endtask

    task automatic load_grid();
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                mem[addr_of(exp_bank, x, y)] = model[y * GW + x];
    endtask

    function automatic int grid_errors();
        int e = 0;
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                if (mem[addr_of(exp_bank, x, y)] !== model[y * GW + x]) e++;
        return e;
    endfunction

    function automatic int img_errors();
        int e = 0;
        for (int i = 0; i < NCELL; i++) if (plot_img[i] != model[i]) e++;
        return e;
    endfunction

    // ---------------- helpers ----------------
    task automatic clear_counts();
        busy_cyc = 0; wr_cnt = 0; plot_cnt = 0; done_cnt = 0;
        for (int i = 0; i < NCELL; i++) plot_img[i] = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic end_gen_checks(input string name, input int exp_busy);
        check({name, "_grid_errs"}, grid_errors(), 0);
        check({name, "_plot_errs"}, img_errors(), 0);
        check({name, "_plots"}, plot_cnt, NCELL);
        check({name, "_writes"}, wr_cnt, NCELL);
        check({name, "_done_pulses"}, done_cnt, 1);
        check({name, "_gen_count"}, 32'(gen_count), exp_gen);
        check({name, "_bank"}, 32'(bank), 32'(exp_bank));
        check({name, "_idle"}, 32'(busy), 0);
        if (exp_busy >= 0) check({name, "_busy_cycles"}, busy_cyc, exp_busy);
    endtask

    task automatic run_step_gen(input string name, input int exp_busy);
        clear_counts();
        pulse_step();
        wait_done(name, 3 * GEN_CYC);
        model_step();
        repeat (2) @(negedge clock);
        end_gen_checks(name, exp_busy);
    endtask

    // ---------------- control vector table ----------------
    typedef struct {
        string name;
        bit    go;
        bit    step;
        bit    stop;
        bit    exp_start;
    } ctl_vec_t;

    ctl_vec_t vecs [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found, stable;
        logic [XB-1:0] px;
        logic [YB-1:0] py;
        logic [2:0]    pc;
        int w0, b0;

        vecs[0] = '{name: "none",        go: 0, step: 0, stop: 0, exp_start: 0};
        vecs[1] = '{name: "step_stop",   go: 0, step: 1, stop: 1, exp_start: 0};
        vecs[2] = '{name: "go_stop",     go: 1, step: 0, stop: 1, exp_start: 0};
        vecs[3] = '{name: "all_three",   go: 1, step: 1, stop: 1, exp_start: 0};
        vecs[4] = '{name: "step",        go: 0, step: 1, stop: 0, exp_start: 1};
        vecs[5] = '{name: "go",          go: 1, step: 0, stop: 0, exp_start: 1};
        vecs[6] = '{name: "stop_only",   go: 0, step: 0, stop: 1, exp_start: 0};

        reset = 1'b1; go = 1'b0; step = 1'b0; stop = 1'b0; plot_ready = 1'b1;
        for (int i = 0; i < 2 ** AW; i++) mem[i] = 1'b0;
        exp_gen = 0; exp_bank = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Reset state.
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_plot_valid", 32'(plot_valid), 0);
        check("rst_bank", 32'(bank), 0);
        check("rst_gen_count", 32'(gen_count), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);

        // IDLE control decode.
        for (int i = 0; i < 7; i++) begin
            random_model();
            load_grid();
            clear_counts();
            go = vecs[i].go; step = vecs[i].step; stop = vecs[i].stop;
            @(negedge clock);
            go = 1'b0; step = 1'b0; stop = 1'b0;
            @(negedge clock);
            check({vecs[i].name, "_busy"}, 32'(busy), 32'(vecs[i].exp_start));
            if (vecs[i].exp_start) begin
                stop = 1'b1;  // drop the run latch; the generation still completes
                wait_done(vecs[i].name, 3 * GEN_CYC);
                stop = 1'b0;
                model_step();
                repeat (2) @(negedge clock);
                end_gen_checks(vecs[i].name, GEN_CYC);
            end else begin
                repeat (5) @(negedge clock);
                check({vecs[i].name, "_no_activity"}, busy_cyc, 0);
            end
        end

        // Horizontal blinker -> vertical blinker.
        clear_model();
        model[2 * GW + 1] = 1'b1; model[2 * GW + 2] = 1'b1; model[2 * GW + 3] = 1'b1;
        load_grid();
        run_step_gen("blinker", GEN_CYC);
        check("blinker_col2",
              32'({mem[addr_of(exp_bank, 2, 1)], mem[addr_of(exp_bank, 2, 2)], mem[addr_of(exp_bank, 2, 3)],
                   mem[addr_of(exp_bank, 1, 2)], mem[addr_of(exp_bank, 3, 2)]}),
              32'b11100);

        // Plot backpressure on cell (0,0) for 5 cycles.
        random_model();
        model[0] = 1'b1; model[1] = 1'b1; model[GW] = 1'b1;  // (0,0) survives
        load_grid();
        clear_counts();
        plot_ready = 1'b0;
        pulse_step();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (plot_valid) found = 1'b1;
            else @(negedge clock);
        end
        check("bp_plot_seen", 32'(found), 1);
        px = plot_x; py = plot_y; pc = plot_colour; w0 = wr_cnt;
        check("bp_first_cell", 32'({px, py}), 0);
        check("bp_first_colour", 32'(pc), 32'h7);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (!plot_valid || plot_x !== px || plot_y !== py || plot_colour !== pc) stable = 1'b0;
        end
        plot_ready = 1'b1;
        check("bp_stable", 32'(stable), 1);
        check("bp_no_extra_wr", wr_cnt - w0, 0);
        wait_done("bp", 3 * GEN_CYC);
        model_step();
        repeat (2) @(negedge clock);
        end_gen_checks("bp", GEN_CYC + 5);

        // go held; stop in cell (2,3) of generation 3.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_gen = 0; exp_bank = 1'b0;
        random_model();
        load_grid();
        clear_counts();
        go = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 4 * GEN_CYC && !found; i++) begin
            @(negedge clock);
            if (gen_count == 16'd2 && plot_valid && plot_x == 4'd2 && plot_y == 4'd3) found = 1'b1;
        end
        check("stop_cell_seen", 32'(found), 1);
        stop = 1'b1; go = 1'b0;
        @(negedge clock);
        stop = 1'b0;
        wait_done("stop_gen3", 2 * GEN_CYC);
        repeat (3) model_step();
        repeat (2) @(negedge clock);
        check("stop_gen_count", 32'(gen_count), 3);
        check("stop_bank", 32'(bank), 32'(exp_bank));
        check("stop_done_pulses", done_cnt, 3);
        check("stop_grid_errs", grid_errors(), 0);
        check("stop_plot_errs", img_errors(), 0);
        b0 = busy_cyc;
        repeat (20) @(negedge clock);
        check("stop_stays_idle", busy_cyc - b0, 0);
        check("stop_total_busy", busy_cyc, 3 * GEN_CYC);

        // Reset in the middle of a PLOT.
        plot_ready = 1'b0;
        pulse_step();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (plot_valid) found = 1'b1;
            else @(negedge clock);
        end
        check("mid_plot_seen", 32'(found), 1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_plot_valid", 32'(plot_valid), 0);
        check("mid_rst_wr_en", 32'(wr_en), 0);
        check("mid_rst_bank", 32'(bank), 0);
        check("mid_rst_gen_count", 32'(gen_count), 0);
        reset = 1'b0; plot_ready = 1'b1;
        exp_gen = 0; exp_bank = 1'b0;
        clear_counts();
        repeat (5) @(negedge clock);
        check("mid_rst_no_restart", busy_cyc, 0);

        // Glider crossing the right/bottom edges.
        clear_model();
        model[0 * GW + 3] = 1'b1; model[1 * GW + 4] = 1'b1;
        model[2 * GW + 2] = 1'b1; model[2 * GW + 3] = 1'b1; model[2 * GW + 4] = 1'b1;
        load_grid();
        for (int g = 0; g < 6; g++) run_step_gen($sformatf("glider%0d", g), GEN_CYC);

        // Random grids with random plot backpressure.
        rand_ready_en = 1'b1;
        for (int g = 0; g < 4; g++) begin
            random_model();
            load_grid();
            run_step_gen($sformatf("rand%0d", g), -1);
        end
        rand_ready_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
